rx_sample_sched: RTL and testbench

- Round-robin read scheduler shared by NCH receiver channels.
- Each channel raises a one-cycle sample-available strobe when its final decimator produces an I/Q sample.
- The block drives the shared rd_i/rd_q read-select lines and captures three 16-bit words per sample: I low, Q low, then {I hi8, Q hi8}.
- It writes the words into a ping-pong sample RAM at deterministic addresses, signals each completed half to the CPU side, and flags per-channel overruns.

---
 rtl/rx_sample_sched_pkg.sv | 25 ++
 rtl/rx_sample_sched_rr_arbiter.sv | 31 +++
 rtl/rx_sample_sched.sv | 151 +++++++++++++++
 tb/tb_rx_sample_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_sample_sched_pkg.sv
// Shared constants for the RX sample scheduler: word-slot encodings,
// FSM state encodings and a constant clog2 helper.
package rx_sample_sched_pkg;

    localparam logic [1:0] WORD_I = 2'd0;
    localparam logic [1:0] WORD_Q = 2'd1;
    localparam logic [1:0] WORD_X = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_I = 2'd1,
        ST_RD_Q = 2'd2,
        ST_RD_X = 2'd3
    } rx_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_sample_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible channel at or above
// ptr, wrapping, returned as one-hot grant plus index.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] eligible,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] grant_idx,
    output logic           valid
);

    int c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        c         = 0;
        for (int i = 0; i < NCH; i++) begin
            c = (int'(ptr) + i) % NCH;
            if (!valid && eligible[c]) begin
                valid     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = CHW'(c);
            end
        end
    end

endmodule

// File: rtl/rx_sample_sched.sv
// Round-robin read scheduler: pulls three words per I/Q sample from NCH
// receiver channels into a ping-pong sample RAM and flags overruns.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no channel in service; grant the first eligible channel
// RD_I    | rd_i asserted, capture I-low word of granted channel
// RD_Q    | rd_q asserted, capture Q-low word
// RD_X    | both selects low, capture hi bytes; frame end / next grant
module rx_sample_sched
    import rx_sample_sched_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int NSAMP = 256,
    localparam int CHW   = (clog2(NCH) < 1) ? 1 : clog2(NCH),
    localparam int SW    = clog2(NSAMP),
    localparam int AW    = 1 + SW + CHW + 2
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic [NCH-1:0]    rx_avail,
    input  logic [NCH*16-1:0] rx_dout,
    input  logic [NCH-1:0]    rx_en,
    output logic              rd_i,
    output logic              rd_q,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [15:0]       wr_data,
    output logic              buf_done,
    output logic              buf_half,
    output logic [NCH-1:0]    overrun,
    input  logic              ovr_clr
);

    rx_state_t      state, state_n;
    logic [NCH-1:0] pending, served, en_lat, cur_oh;
    logic [CHW-1:0] cur_idx, rr_ptr, rr_next;
    logic [SW-1:0]  sample_idx;
    logic           half;

    logic [NCH-1:0] elig, gnt_oh, served_acc, en_eff;
    logic [CHW-1:0] gnt_idx;
    logic           gnt_vld, take, frame_end, wrap, cap;
    logic [1:0]     word_sel;
    logic [15:0]    dout_sel;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .eligible  (elig),
        .ptr       (rr_ptr),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .valid     (gnt_vld)
    );

    always_comb begin
        served_acc = served | cur_oh;
        frame_end  = (state == ST_RD_X) && (served_acc == en_lat);
        wrap       = frame_end && (sample_idx == SW'(NSAMP - 1));
        en_eff     = frame_end ? rx_en : en_lat;
        elig       = '0;
        // A grant at frame end already belongs to the next frame.
        if (state == ST_IDLE)
            elig = pending & ~served & en_lat;
        else if (state == ST_RD_X)
            elig = pending & ~(frame_end ? '0 : served_acc) & en_eff;
        take    = gnt_vld;
        rr_next = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
    end

    always_comb begin
        state_n  = state;
        rd_i     = 1'b0;
        rd_q     = 1'b0;
        cap      = 1'b0;
        word_sel = WORD_I;
        case (state)
            ST_IDLE: if (take) state_n = ST_RD_I;
            ST_RD_I: begin
                rd_i     = 1'b1;
                cap      = 1'b1;
                word_sel = WORD_I;
                state_n  = ST_RD_Q;
            end
            ST_RD_Q: begin
                rd_q     = 1'b1;
                cap      = 1'b1;
                word_sel = WORD_Q;
                state_n  = ST_RD_X;
            end
            ST_RD_X: begin
                cap      = 1'b1;
                word_sel = WORD_X;
                state_n  = take ? ST_RD_I : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        dout_sel = '0;
        for (int n = 0; n < NCH; n++) begin
            if (cur_idx == CHW'(n)) dout_sel = rx_dout[16*n +: 16];
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= '0;
            served     <= '0;
            en_lat     <= '0;
            cur_oh     <= '0;
            cur_idx    <= '0;
            rr_ptr     <= '0;
            sample_idx <= '0;
            half       <= 1'b0;
            overrun    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            buf_done   <= 1'b0;
            buf_half   <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= (pending & ~(take ? gnt_oh : '0)) | (rx_avail & en_lat);
            overrun <= (ovr_clr ? '0 : overrun) | (rx_avail & pending);
            if (take) begin
                cur_oh  <= gnt_oh;
                cur_idx <= gnt_idx;
                rr_ptr  <= rr_next;
            end
            if (frame_end) begin
                served     <= '0;
                en_lat     <= rx_en;
                sample_idx <= sample_idx + SW'(1);
                if (wrap) half <= ~half;
            end else begin
                if (state == ST_RD_X) served <= served_acc;
                if (en_lat == '0) en_lat <= rx_en;
            end
            wr_en <= cap;
            if (cap) begin
                wr_data <= dout_sel;
                wr_addr <= {half, sample_idx, cur_idx, word_sel};
            end
            buf_done <= wrap;
            buf_half <= wrap ? half : 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_sample_sched.sv
// Directed bench for rx_sample_sched with NCH=4, NSAMP=4 and a simple
// per-channel read-data model driven by rd_i/rd_q.
module tb_rx_sample_sched;

    logic        adc_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [3:0]  rx_avail = '0;
    logic [63:0] rx_dout;
    logic [3:0]  rx_en   = 4'b0001;
    logic        rd_i, rd_q, wr_en, buf_done, buf_half, ovr_clr;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [15:0] i_lo [4] = '{16'h1111, 16'h1112, 16'h1113, 16'h1114};
    logic [15:0] q_lo [4] = '{16'h2222, 16'h2223, 16'h2224, 16'h2225};
    logic [15:0] x_hi [4] = '{16'h3344, 16'h3355, 16'h3366, 16'h3377};

    typedef struct {
        logic        we;
        logic        bd;
        logic        bh;
        logic [6:0]  a;
        logic [15:0] d;
        int          cyc;
    } wr_t;
    wr_t wq[$];

    rx_sample_sched #(.NCH(4), .NSAMP(4)) dut (
        .adc_clk  (adc_clk),
        .reset    (reset),
        .rx_avail (rx_avail),
        .rx_dout  (rx_dout),
        .rx_en    (rx_en),
        .rd_i     (rd_i),
        .rd_q     (rd_q),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .buf_done (buf_done),
        .buf_half (buf_half),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr)
    );

    always #5 adc_clk = ~adc_clk;

    always_comb begin
        rx_dout = '0;
        for (int n = 0; n < 4; n++)
            rx_dout[16*n +: 16] = rd_i ? i_lo[n] : (rd_q ? q_lo[n] : x_hi[n]);
    end

    always @(posedge adc_clk) cyc <= cyc + 1;

    always @(negedge adc_clk) begin
        if (wr_en || buf_done)
            wq.push_back('{we: wr_en, bd: buf_done, bh: buf_half,
                           a: wr_addr, d: wr_data, cyc: cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [3:0] m);
        rx_avail = m;
        tick();
        rx_avail = '0;
    endtask

    task automatic do_reset(input logic [3:0] en);
        rx_en = en;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        wq.delete();
    endtask

    function automatic logic [6:0] ea(input int h, input int s, input int c, input int w);
        return {h[0], s[1:0], c[1:0], w[1:0]};
    endfunction

    function automatic logic [15:0] ed(input int c, input int w);
        return (w == 0) ? i_lo[c] : ((w == 1) ? q_lo[c] : x_hi[c]);
    endfunction

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rd_i"},  32'(rd_i), 0);
        chk({tag, "_rd_q"},  32'(rd_q), 0);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_addr"},  32'(wr_addr), 0);
        chk({tag, "_data"},  32'(wr_data), 0);
        chk({tag, "_bd"},    32'(buf_done), 0);
        chk({tag, "_bh"},    32'(buf_half), 0);
        chk({tag, "_ovr"},   32'(overrun), 0);
    endtask

    initial begin
        int c2;
        ovr_clr = 1'b0;
        idle(3);
        @(negedge adc_clk);
        chk_outs_zero("reset");

        // 1: single channel latency and word order
        do_reset(4'b0001);
        pulse(4'b0001);
        @(negedge adc_clk);
        chk("t1_rd_i_t1", 32'(rd_i), 0);
        chk("t1_wr_en_t1", 32'(wr_en), 0);
        @(negedge adc_clk);
        chk("t1_rd_i_t2", 32'(rd_i), 1);
        chk("t1_rd_q_t2", 32'(rd_q), 0);
        for (int w = 0; w < 3; w++) begin
            @(negedge adc_clk);
            chk($sformatf("t1_wr_en_w%0d", w), 32'(wr_en), 1);
            chk($sformatf("t1_addr_w%0d", w), 32'(wr_addr), 32'(w));
            chk($sformatf("t1_data_w%0d", w), 32'(wr_data), 32'(ed(0, w)));
            if (w == 0) chk("t1_rd_q_t3", 32'(rd_q), 1);
        end
        @(negedge adc_clk);
        chk("t1_wr_en_t6", 32'(wr_en), 0);

        // 5: four more samples -> half 0 completes on write 12, write 13 in half 1
        for (int s = 1; s < 5; s++) begin
            pulse(4'b0001);
            idle(6);
        end
        chk("t5_nwr", 32'(wq.size()), 15);
        if (wq.size() == 15) begin
            for (int k = 0; k < 15; k++) begin
                chk($sformatf("t5_we%0d", k), 32'(wq[k].we), 1);
                chk($sformatf("t5_addr%0d", k), 32'(wq[k].a), 32'(ea((k/3)/4, (k/3)%4, 0, k%3)));
                chk($sformatf("t5_data%0d", k), 32'(wq[k].d), 32'(ed(0, k%3)));
                chk($sformatf("t5_bd%0d", k), 32'(wq[k].bd), (k == 11) ? 1 : 0);
            end
            chk("t5_bh12", 32'(wq[11].bh), 0);
            chk("t5_addr13", 32'(wq[12].a), 32'h40);
        end

        // 2: all four channels, two frames; rr order restarts at channel 0
        do_reset(4'b1111);
        pulse(4'b1111);
        idle(15);
        pulse(4'b1111);
        idle(15);
        chk("t2_nwr", 32'(wq.size()), 24);
        if (wq.size() == 24) begin
            for (int k = 0; k < 24; k++) begin
                chk($sformatf("t2_addr%0d", k), 32'(wq[k].a), 32'(ea(0, k/12, (k%12)/3, k%3)));
                chk($sformatf("t2_data%0d", k), 32'(wq[k].d), 32'(ed((k%12)/3, k%3)));
                chk($sformatf("t2_bd%0d", k), 32'(wq[k].bd), 0);
                chk($sformatf("t2_gap%0d", k), 32'(wq[k].cyc - wq[(k/12)*12].cyc), 32'(k%12));
            end
        end

        // 3: channel 2 strobes twice while channel 0 is in service
        do_reset(4'b1111);
        rx_avail = 4'b0001;
        tick();
        rx_avail = 4'b0100;
        tick();
        tick();
        rx_avail = 4'b0000;
        @(negedge adc_clk);
        chk("t3_ovr", 32'(overrun), 32'h4);
        idle(12);
        @(negedge adc_clk);
        chk("t3_ovr_sticky", 32'(overrun), 32'h4);
        chk("t3_nwr", 32'(wq.size()), 6);
        c2 = 0;
        foreach (wq[k]) if (wq[k].a[3:2] == 2'd2) c2++;
        chk("t3_ch2_nwr", 32'(c2), 3);
        if (wq.size() == 6) begin
            for (int k = 3; k < 6; k++) begin
                chk($sformatf("t3_addr%0d", k), 32'(wq[k].a), 32'(ea(0, 0, 2, k-3)));
                chk($sformatf("t3_data%0d", k), 32'(wq[k].d), 32'(ed(2, k-3)));
            end
        end
        tick();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        @(negedge adc_clk);
        chk("t3_ovr_clr", 32'(overrun), 0);

        // 4: channel 0 second sample held until channel 1 closes frame 0
        do_reset(4'b0011);
        pulse(4'b0001);
        idle(6);
        pulse(4'b0001);
        idle(4);
        pulse(4'b0010);
        idle(12);
        chk("t4_nwr", 32'(wq.size()), 9);
        chk("t4_ovr", 32'(overrun), 0);
        if (wq.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                chk($sformatf("t4_addr%0d", k), 32'(wq[k].a),
                    32'(ea(0, (k >= 6) ? 1 : 0, (k >= 3 && k < 6) ? 1 : 0, k%3)));
                chk($sformatf("t4_data%0d", k), 32'(wq[k].d),
                    32'(ed((k >= 3 && k < 6) ? 1 : 0, k%3)));
            end
            chk("t4_b2b", 32'(wq[6].cyc - wq[3].cyc), 3);
        end

        // 6: reset while in RD_Q aborts the sample
        do_reset(4'b0001);
        pulse(4'b0001);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge adc_clk);
        chk_outs_zero("t6_post");
        chk("t6_pre_nwr", 32'(wq.size()), 1);
        wq.delete();
        idle(8);
        chk("t6_quiet", 32'(wq.size()), 0);
        pulse(4'b0001);
        idle(6);
        chk("t6_nwr", 32'(wq.size()), 3);
        if (wq.size() == 3) begin
            chk("t6_addr0", 32'(wq[0].a), 0);
            chk("t6_data0", 32'(wq[0].d), 32'h1111);
            chk("t6_addr2", 32'(wq[2].a), 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
